// File: rtl/sap1_controller.sv
// SAP-1 controller-sequencer: a one-hot T1..T6 ring counter plus an opcode decoder
// that produces the per-T-state control word, including the ALU select/enable.
module sap1_controller #(
  parameter bit SKIP_NOP = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] opcode,
  output logic       ep,
  output logic       cp,
  output logic       lm,
  output logic       ce,
  output logic       li,
  output logic       ei,
  output logic       la,
  output logic       ea,
  output logic       lb,
  output logic       eu,
  output logic [2:0] su,
  output logic       lo,
  output logic       hlt,
  output logic [5:0] t_state
);

  localparam logic [5:0] T1 = 6'b000001;
  localparam logic [5:0] T2 = 6'b000010;
  localparam logic [5:0] T3 = 6'b000100;
  localparam logic [5:0] T4 = 6'b001000;
  localparam logic [5:0] T5 = 6'b010000;
  localparam logic [5:0] T6 = 6'b100000;

  logic [5:0] t_q, t_d;
  logic       halted_q, halted_d;
  logic       is_lda, is_bin, is_unary, is_out, is_hlt, is_nop;

  // Ring-counter state and halted flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      t_q      <= T1;
      halted_q <= 1'b0;
    end else begin
      t_q      <= t_d;
      halted_q <= halted_d;
    end
  end

  // Opcode class decode
  always_comb begin
    is_lda   = 1'b0;
    is_bin   = 1'b0;
    is_unary = 1'b0;
    is_out   = 1'b0;
    is_hlt   = 1'b0;
    is_nop   = 1'b0;
    case (opcode)
      4'b0000:                            is_lda   = 1'b1;
      4'b0001, 4'b0010, 4'b0011, 4'b0100: is_bin   = 1'b1;
      4'b0101, 4'b0110, 4'b0111:          is_unary = 1'b1;
      4'b1110:                            is_out   = 1'b1;
      4'b1111:                            is_hlt   = 1'b1;
      default:                            is_nop   = 1'b1;
    endcase
  end

  // Next-state: ring advance, early return to T1, and halt freeze at T4
  always_comb begin
    t_d      = T1;
    halted_d = halted_q;
    if (halted_q) begin
      t_d = T4;
    end else begin
      case (t_q)
        T1: t_d = T2;
        T2: t_d = T3;
        T3: t_d = (SKIP_NOP && is_nop) ? T1 : T4;
        T4: begin
          if (is_hlt) begin
            t_d      = T4;
            halted_d = 1'b1;
          end else if (SKIP_NOP && (is_unary || is_out)) begin
            t_d = T1;
          end else begin
            t_d = T5;
          end
        end
        T5: t_d = (SKIP_NOP && is_lda) ? T1 : T6;
        T6: t_d = T1;
        // A corrupted (non one-hot) state recovers to the start of fetch
        default: t_d = T1;
      endcase
    end
  end

  // Control word from the registered T-state and the live opcode
  always_comb begin
    ep = 1'b0; cp = 1'b0; lm = 1'b0; ce = 1'b0; li = 1'b0; ei = 1'b0;
    la = 1'b0; ea = 1'b0; lb = 1'b0; eu = 1'b0; su = 3'b000; lo = 1'b0;
    hlt = 1'b0;
    if (halted_q) begin
      hlt = 1'b1;
    end else begin
      case (t_q)
        T1: begin ep = 1'b1; lm = 1'b1; end
        T2: cp = 1'b1;
        T3: begin ce = 1'b1; li = 1'b1; end
        T4: begin
          case (opcode)
            4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0100: begin ei = 1'b1; lm = 1'b1; end
            4'b0101: begin eu = 1'b1; la = 1'b1; su = 3'b100; end
            4'b0110: begin eu = 1'b1; la = 1'b1; su = 3'b101; end
            4'b0111: begin eu = 1'b1; la = 1'b1; su = 3'b110; end
            4'b1110: begin ea = 1'b1; lo = 1'b1; end
            4'b1111: hlt = 1'b1;
            default: ;
          endcase
        end
        T5: begin
          case (opcode)
            4'b0000:                            begin ce = 1'b1; la = 1'b1; end
            4'b0001, 4'b0010, 4'b0011, 4'b0100: begin ce = 1'b1; lb = 1'b1; end
            default: ;
          endcase
        end
        T6: begin
          case (opcode)
            4'b0001: begin eu = 1'b1; la = 1'b1; su = 3'b000; end
            4'b0010: begin eu = 1'b1; la = 1'b1; su = 3'b001; end
            4'b0011: begin eu = 1'b1; la = 1'b1; su = 3'b010; end
            4'b0100: begin eu = 1'b1; la = 1'b1; su = 3'b011; end
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

  assign t_state = t_q;

endmodule
